// File: rtl/enokida_arb_pkg.sv
// Shared types for the Enokida memory arbiter: FSM states, owner encoding and
// the starvation counter width.
package enokida_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StResp
  } arb_state_e;

  typedef enum logic {
    OwnM0 = 1'b0,
    OwnM1 = 1'b1
  } owner_e;

  // Wide enough for any starvation limit in 1..15.
  localparam int unsigned StarveCntWidth = 4;

endpackage

// File: rtl/enokida_mem_arbiter_if.sv
// Bundle of the two requester ports, the shared memory port and the per-master
// completion counters seen by the Enokida memory arbiter.
interface enokida_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic                  m0_req_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [BeWidth-1:0]    m0_be_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic                  m0_gnt_o;
  logic                  m0_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o;

  logic                  m1_req_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [BeWidth-1:0]    m1_be_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic                  m1_gnt_o;
  logic                  m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m1_rdata_o;
  logic                  m1_enable_i;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [BeWidth-1:0]    mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic [31:0]           m0_grants_o;
  logic [31:0]           m1_grants_o;

  // Arbiter side.
  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_enable_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output m0_grants_o, m1_grants_o
  );

  // Environment side: requesters plus memory.
  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_enable_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  m0_grants_o, m1_grants_o
  );

endinterface

// File: rtl/enokida_arb_pick.sv
// Combinational owner selection: M0 has fixed priority unless M1 has been
// passed over STARVE_LIMIT times in a row.
module enokida_arb_pick
  import enokida_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      m0_req_i,
  input  logic                      m1_req_i,
  input  logic                      m1_enable_i,
  input  logic [StarveCntWidth-1:0] starve_cnt_i,
  output logic                      pick_valid_o,
  output owner_e                    pick_owner_o
);

  localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(STARVE_LIMIT);

  logic m1_contending;
  assign m1_contending = m1_req_i & m1_enable_i;

  always_comb begin
    pick_valid_o = 1'b1;
    pick_owner_o = OwnM0;
    if (m1_contending && (starve_cnt_i == StarveMax)) begin
      pick_owner_o = OwnM1;
    end else if (m0_req_i) begin
      pick_owner_o = OwnM0;
    end else if (m1_contending) begin
      pick_owner_o = OwnM1;
    end else begin
      pick_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/enokida_mem_arbiter.sv
// Two-master arbiter for a single RI5CY-style memory port: one outstanding
// transaction, responses routed back to the owner, completions counted.
module enokida_mem_arbiter
  import enokida_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  enokida_mem_arbiter_if.slave bus
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  owner_e                    owner_q, owner_d;
  logic [StarveCntWidth-1:0] starve_q, starve_d;
  logic [31:0]               m0_cnt_q, m0_cnt_d;
  logic [31:0]               m1_cnt_q, m1_cnt_d;

  logic                      pick_valid;
  owner_e                    pick_owner;
  logic                      m1_contending;
  logic                      owner_req;

  logic                      mem_req;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic                      mem_we;
  logic [BeWidth-1:0]        mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      m0_gnt, m1_gnt;
  logic                      m0_rvalid, m1_rvalid;
  logic [DATA_WIDTH-1:0]     m0_rdata, m1_rdata;

  enokida_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .m0_req_i    (bus.m0_req_i),
    .m1_req_i    (bus.m1_req_i),
    .m1_enable_i (bus.m1_enable_i),
    .starve_cnt_i(starve_q),
    .pick_valid_o(pick_valid),
    .pick_owner_o(pick_owner)
  );

  assign m1_contending = bus.m1_req_i & bus.m1_enable_i;
  assign owner_req     = (owner_q == OwnM1) ? bus.m1_req_i : bus.m0_req_i;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    m0_cnt_d  = m0_cnt_q;
    m1_cnt_d  = m1_cnt_q;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StAddr;
          owner_d = pick_owner;
        end
        // Count only M0 wins that actually made a contending M1 wait.
        if (pick_valid && (pick_owner == OwnM1)) begin
          starve_d = '0;
        end else if (pick_valid && m1_contending) begin
          starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveCntWidth'(1);
        end else if (!m1_contending) begin
          starve_d = '0;
        end
      end
      StAddr: begin
        mem_req = 1'b1;
        unique case (owner_q)
          OwnM0: begin
            mem_addr  = bus.m0_addr_i;
            mem_we    = bus.m0_we_i;
            mem_be    = bus.m0_be_i;
            mem_wdata = bus.m0_wdata_i;
            m0_gnt    = bus.mem_gnt_i;
          end
          OwnM1: begin
            mem_addr  = bus.m1_addr_i;
            mem_we    = bus.m1_we_i;
            mem_be    = bus.m1_be_i;
            mem_wdata = bus.m1_wdata_i;
            m1_gnt    = bus.mem_gnt_i;
          end
        endcase
        if (bus.mem_gnt_i) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.mem_rvalid_i) begin
          state_d = StIdle;
          unique case (owner_q)
            OwnM0: begin
              m0_rvalid = 1'b1;
              m0_rdata  = bus.mem_rdata_i;
              m0_cnt_d  = m0_cnt_q + 32'd1;
            end
            OwnM1: begin
              m1_rvalid = 1'b1;
              m1_rdata  = bus.mem_rdata_i;
              m1_cnt_d  = m1_cnt_q + 32'd1;
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= OwnM0;
      starve_q <= '0;
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.m0_gnt_o    = m0_gnt;
  assign bus.m1_gnt_o    = m1_gnt;
  assign bus.m0_rvalid_o = m0_rvalid;
  assign bus.m1_rvalid_o = m1_rvalid;
  assign bus.m0_rdata_o  = m0_rdata;
  assign bus.m1_rdata_o  = m1_rdata;
  assign bus.m0_grants_o = m0_cnt_q;
  assign bus.m1_grants_o = m1_cnt_q;

  // The owner must keep its request up until the memory grants it.
  owner_req_held: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == StAddr) |-> owner_req
  );

endmodule

// File: tb/tb_enokida_mem_arbiter.sv
// Self-checking bench for enokida_mem_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_enokida_mem_arbiter;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enokida_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  enokida_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fixed request bundles for directed tests.
  localparam logic [15:0] A0 = 16'h0040;
  localparam logic [15:0] A1 = 16'h0100;
  localparam logic [31:0] W1 = 32'h1234_5678;

  task automatic drive(input bit m0r, input bit m1r, input bit en, input bit g, input bit rv,
                       input logic [31:0] rd);
    bus.m0_req_i = m0r; bus.m0_addr_i = A0; bus.m0_we_i = 1'b0; bus.m0_be_i = 4'hF;
    bus.m0_wdata_i = 32'h0;
    bus.m1_req_i = m1r; bus.m1_addr_i = A1; bus.m1_we_i = 1'b1; bus.m1_be_i = 4'hF;
    bus.m1_wdata_i = W1;
    bus.m1_enable_i = en; bus.mem_gnt_i = g; bus.mem_rvalid_i = rv; bus.mem_rdata_i = rd;
  endtask

  typedef struct {
    bit          m0r, m1r, en, g, rv;
    logic [31:0] rd;
    bit          emr;   // expect mem_req_o
    bit          esrc;  // expected bundle source when emr: 0=M0, 1=M1
    bit          eg0, eg1, ev0, ev1;
    logic [31:0] erd0, erd1;
  } vec_t;

  function automatic vec_t mk(input bit m0r, input bit m1r, input bit en, input bit g,
                              input bit rv, input logic [31:0] rd, input bit emr, input bit esrc,
                              input bit eg0, input bit eg1, input bit ev0, input bit ev1,
                              input logic [31:0] erd0, input logic [31:0] erd1);
    vec_t v;
    v.m0r = m0r; v.m1r = m1r; v.en = en; v.g = g; v.rv = rv; v.rd = rd;
    v.emr = emr; v.esrc = esrc; v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
    v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  vec_t tbl[14];

  // Behavioural model state for the random phase.
  int          ph;        // 0 idle, 1 address, 2 response
  int          own;
  int          starve;
  logic [31:0] cnt[2];
  bit          req[2];
  logic [15:0] addr[2];
  bit          we[2];
  logic [3:0]  be[2];
  logic [31:0] wd[2];

  initial begin
    int got[$];
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit en;

    drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
    #2;
    chk("reset mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("reset mem_addr", 32'(bus.mem_addr_o), 32'h0);
    chk("reset gnt", {30'h0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'h0);
    chk("reset rvalid", {30'h0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 32'h0);
    chk("reset rdata0", bus.m0_rdata_o, 32'h0);
    chk("reset cnt0", bus.m0_grants_o, 32'h0);
    chk("reset cnt1", bus.m1_grants_o, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // m0r m1r en g rv rd | emr src g0 g1 v0 v1 rd0 rd1
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 32'hDEADBEEF,  0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[6]  = mk(0, 1, 0, 0, 1, 32'h1111,      0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[10] = mk(0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tbl[11] = mk(0, 1, 1, 1, 1, 32'h2222,      1, 1, 0, 1, 0, 0, 32'h0, 32'h0);
    tbl[12] = mk(0, 0, 1, 0, 1, 32'hCAFEF00D,  0, 0, 0, 0, 0, 1, 32'h0, 32'hCAFEF00D);
    tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].m0r, tbl[i].m1r, tbl[i].en, tbl[i].g, tbl[i].rv, tbl[i].rd);
      #1;
      chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req_o), 32'(tbl[i].emr));
      chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr_o),
          !tbl[i].emr ? 32'h0 : (tbl[i].esrc ? 32'(A1) : 32'(A0)));
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we_o), 32'(tbl[i].emr && tbl[i].esrc));
      chk($sformatf("v%0d mem_be", i), 32'(bus.mem_be_o), tbl[i].emr ? 32'hF : 32'h0);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata_o,
          (tbl[i].emr && tbl[i].esrc) ? W1 : 32'h0);
      chk($sformatf("v%0d m0_gnt", i), 32'(bus.m0_gnt_o), 32'(tbl[i].eg0));
      chk($sformatf("v%0d m1_gnt", i), 32'(bus.m1_gnt_o), 32'(tbl[i].eg1));
      chk($sformatf("v%0d m0_rvalid", i), 32'(bus.m0_rvalid_o), 32'(tbl[i].ev0));
      chk($sformatf("v%0d m1_rvalid", i), 32'(bus.m1_rvalid_o), 32'(tbl[i].ev1));
      chk($sformatf("v%0d m0_rdata", i), bus.m0_rdata_o, tbl[i].erd0);
      chk($sformatf("v%0d m1_rdata", i), bus.m1_rdata_o, tbl[i].erd1);
      @(negedge clk);
    end
    chk("table cnt0", bus.m0_grants_o, 32'd1);
    chk("table cnt1", bus.m1_grants_o, 32'd1);

    // M1 locked out for 20 cycles even with memory granting.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 1, 0, 32'h0);
      #1;
      chk("lock mem_req/m1_gnt", {30'h0, bus.mem_req_o, bus.m1_gnt_o}, 32'h0);
      @(negedge clk);
    end
    drive(0, 1, 1, 1, 0, 32'h0);
    #1 chk("unlock bubble mem_req", 32'(bus.mem_req_o), 32'h0);
    @(negedge clk);
    #1 chk("unlock m1_gnt", 32'(bus.m1_gnt_o), 32'h1);
    @(negedge clk);
    drive(0, 0, 1, 0, 1, 32'h5);
    #1 chk("unlock m1_rvalid", 32'(bus.m1_rvalid_o), 32'h1);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 32'h0);
    @(negedge clk);

    // Both request continuously; memory grants and responds immediately.
    drive(1, 1, 1, 1, 1, 32'h77);
    for (int c = 0; c < 100 && got.size() < 10; c++) begin
      #1;
      if (bus.m0_gnt_o) got.push_back(0);
      if (bus.m1_gnt_o) got.push_back(1);
      @(negedge clk);
    end
    chk("starve grant count", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("starve order %0d", i), 32'(got[i]), 32'(exp_order[i]));
    drive(0, 0, 1, 0, 1, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Enable dropped while M1 waits for its response.
    drive(0, 1, 1, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 32'h0);
    #1 chk("endrop m1_gnt", 32'(bus.m1_gnt_o), 32'h1);
    @(negedge clk);
    drive(1, 1, 0, 0, 1, 32'hA5A5_0001);
    #1 chk("endrop m1_rvalid", 32'(bus.m1_rvalid_o), 32'h1);
    chk("endrop m1_rdata", bus.m1_rdata_o, 32'hA5A5_0001);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 32'h0);
    #1 chk("endrop next gnt", {30'h0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'h1);
    chk("endrop next addr", 32'(bus.mem_addr_o), 32'(A0));
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h9);
    #1 chk("endrop m0_rvalid", 32'(bus.m0_rvalid_o), 32'h1);
    @(negedge clk);

    // Reset while a transaction waits in the response phase.
    drive(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    #1;
    chk("stray rvalid", {30'h0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 32'h0);
    chk("stray rdata0", bus.m0_rdata_o, 32'h0);
    chk("post-reset cnt0", bus.m0_grants_o, 32'h0);
    chk("post-reset cnt1", bus.m1_grants_o, 32'h0);
    @(negedge clk);
    #1 chk("stray rvalid later", {30'h0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    ph = 0; own = 0; starve = 0; cnt[0] = 0; cnt[1] = 0; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; addr[k] = 0; we[k] = 0; be[k] = 0; wd[k] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      bit g, rv, act, m1c;
      bit eg[2], ev[2];
      logic [31:0] rd;
      for (int k = 0; k < 2; k++) begin
        if (!req[k] && $urandom_range(2) == 0) begin
          req[k] = 1; addr[k] = 16'($urandom); we[k] = 1'($urandom);
          be[k] = 4'($urandom); wd[k] = $urandom;
        end
      end
      if ($urandom_range(15) == 0) en = ~en;
      g = 1'($urandom); rv = ($urandom_range(2) == 0); rd = $urandom;
      bus.m0_req_i = req[0]; bus.m0_addr_i = addr[0]; bus.m0_we_i = we[0];
      bus.m0_be_i = be[0]; bus.m0_wdata_i = wd[0];
      bus.m1_req_i = req[1]; bus.m1_addr_i = addr[1]; bus.m1_we_i = we[1];
      bus.m1_be_i = be[1]; bus.m1_wdata_i = wd[1];
      bus.m1_enable_i = en; bus.mem_gnt_i = g; bus.mem_rvalid_i = rv; bus.mem_rdata_i = rd;
      #1;
      act = (ph == 1);
      for (int k = 0; k < 2; k++) begin
        eg[k] = act && own == k && g;
        ev[k] = (ph == 2) && own == k && rv;
      end
      chk("rnd mem_req", 32'(bus.mem_req_o), 32'(act));
      chk("rnd mem_addr", 32'(bus.mem_addr_o), act ? 32'(addr[own]) : 32'h0);
      chk("rnd mem_we", 32'(bus.mem_we_o), act ? 32'(we[own]) : 32'h0);
      chk("rnd mem_be", 32'(bus.mem_be_o), act ? 32'(be[own]) : 32'h0);
      chk("rnd mem_wdata", bus.mem_wdata_o, act ? wd[own] : 32'h0);
      chk("rnd gnt", {30'h0, bus.m1_gnt_o, bus.m0_gnt_o}, {30'h0, eg[1], eg[0]});
      chk("rnd rvalid", {30'h0, bus.m1_rvalid_o, bus.m0_rvalid_o}, {30'h0, ev[1], ev[0]});
      chk("rnd m0_rdata", bus.m0_rdata_o, ev[0] ? rd : 32'h0);
      chk("rnd m1_rdata", bus.m1_rdata_o, ev[1] ? rd : 32'h0);
      chk("rnd cnt0", bus.m0_grants_o, cnt[0]);
      chk("rnd cnt1", bus.m1_grants_o, cnt[1]);
      @(posedge clk);
      m1c = req[1] && en;
      if (ph == 0) begin
        if (m1c && starve == LIM) begin own = 1; ph = 1; starve = 0; end
        else if (req[0]) begin
          own = 0; ph = 1;
          starve = m1c ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        end
        else if (m1c) begin own = 1; ph = 1; starve = 0; end
        else starve = 0;
      end else if (ph == 1) begin
        if (g) ph = 2;
      end else if (rv) begin
        cnt[own] = cnt[own] + 1;
        ph = 0;
      end
      for (int k = 0; k < 2; k++) if (eg[k]) req[k] = 0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enokida_mem_arbiter.md
Name: enokida_mem_arbiter

Overview:
- Shares the single RI5CY-protocol memory port between two requesters: the Enokida cache refill/writeback port (M0) and the trace-driven prefetch engine (M1).
- Sits between the cache's cache_mem_* port, the prefetcher, and data memory.
- Tracks one outstanding transaction and routes each rvalid/rdata back to its owner.
- M0 has fixed priority, with a starvation bound protecting M1.

Parameters:
ADDR_WIDTH, 16, address width of all ports
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
STARVE_LIMIT, 4, consecutive M0 grants while M1 waits before M1 is forced to win (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
m0_req_i  input  1  M0 request
m0_addr_i  input  ADDR_WIDTH  M0 address
m0_we_i  input  1  M0 write enable
m0_be_i  input  DATA_WIDTH/8  M0 byte enables
m0_wdata_i  input  DATA_WIDTH  M0 write data
m0_gnt_o  output  1  M0 grant
m0_rvalid_o  output  1  M0 response valid
m0_rdata_o  output  DATA_WIDTH  M0 read data
m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i  input  as M0  M1 request bundle
m1_gnt_o, m1_rvalid_o, m1_rdata_o  output  as M0  M1 response bundle
m1_enable_i  input  1  0 = M1 never arbitrated (prefetch lock)
mem_req_o  output  1  memory request
mem_addr_o  output  ADDR_WIDTH  memory address
mem_we_o  output  1  memory write enable
mem_be_o  output  DATA_WIDTH/8  memory byte enables
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_gnt_i  input  1  memory grant
mem_rvalid_i  input  1  memory response valid
mem_rdata_i  input  DATA_WIDTH  memory read data
m0_grants_o  output  32  count of completed M0 transactions (wraps)
m1_grants_o  output  32  count of completed M1 transactions (wraps)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, owner=M0, starve_cnt=0, both counters 0.
  - All *_req_o, *_gnt_o and *_rvalid_o are 0; data/address outputs are 0.
- Reset mid-transaction: the transaction is abandoned. A later stray mem_rvalid_i in IDLE is ignored and is not routed.
- Masters hold req and the whole bundle stable until they see gnt.
- FSM IDLE:
  - Sample the requests and pick the owner, then go to ADDR next cycle.
  - Arbitration gives a one-cycle bubble.
- Arbitration order:
  - If m1_req_i && m1_enable_i && starve_cnt==STARVE_LIMIT, pick M1.
  - Else if m0_req_i, pick M0.
  - Else if m1_req_i && m1_enable_i, pick M1.
  - Else stay in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when M0 is picked while M1 is requesting and enabled.
  - Clears when M1 is picked, or when M1 is not requesting in IDLE.
- FSM ADDR:
  - mem_req_o=1. mem_addr/we/be/wdata pass combinationally from the owner's inputs.
  - Owner gnt_o = mem_gnt_i, combinational, same cycle. The non-owner gnt_o is 0.
  - On mem_gnt_i: a write goes to RESP; a read also goes to RESP (RI5CY returns rvalid for both).
- FSM RESP:
  - mem_req_o=0.
  - On mem_rvalid_i: owner rvalid_o=1 and owner rdata_o=mem_rdata_i in the same cycle, combinationally.
  - The owner's counter increments and the FSM returns to IDLE.
  - Back-to-back transactions therefore need at least one IDLE cycle between them.
- Non-owner rvalid_o is always 0; its rdata_o is 0 whenever its rvalid_o is 0.
- mem_rvalid_i seen in IDLE or ADDR is ignored.
- m1_enable_i falling while M1 owns ADDR or RESP: the transaction still completes. Only new arbitration is blocked.
- Owner dropping req in ADDR is a protocol violation. It must not occur; an assertion flags it.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.

Decomposition:
- Package enokida_arb_pkg holds:
  - the state enum {IDLE, ADDR, RESP};
  - the owner typedef (1-bit: OWN_M0, OWN_M1).
- Sub-module enokida_arb_pick: purely combinational priority/starvation decision. Inputs: requests, enable, starve_cnt. Outputs: pick_valid, pick_owner.
- The FSM, mux and counters stay in the top module.

Test Plan:
- M0 read addr 0x0040, mem gnt at cycle 1 of ADDR, rvalid 2 cycles later with rdata 0xDEADBEEF -> m0_rvalid_o=1 with 0xDEADBEEF; m1_rvalid_o=0; m0_grants_o=1.
- M0 and M1 both request continuously, STARVE_LIMIT=4 -> grant order M0,M0,M0,M0,M1,M0,...; m1 never waits more than 4 M0 transactions.
- m1_enable_i=0, M1 requests alone for 20 cycles -> mem_req_o stays 0 and m1_gnt_o stays 0; setting enable=1 gives M1 the grant after a 1-cycle bubble.
- M1 write addr 0x0100, wdata 0x12345678, be 0xF, gnt delayed 3 cycles -> mem_* bundle stable for all 3 cycles; m1_gnt_o pulses with mem_gnt_i; m1_grants_o=1 after rvalid.
- rst_n asserted during RESP, then a stray mem_rvalid_i arrives -> no rvalid on either master; both counters are 0.
- m1_enable_i dropped while M1 is in RESP -> M1 response still delivered; next arbitration picks M0 only.
